// File: rtl/udp_arb_pkg.sv
// udp_arb_pkg
//   Shared definitions for the UDP TX port arbiter: the layout of the 96-bit
//   status word, the arbiter FSM state encoding and the default size limit.
//   Status word layout: [95:48] dest MAC, [47:16] dest IP, [15:0] payload length.
package udp_arb_pkg;

  localparam int unsigned STATUS_W = 96;

  localparam int unsigned MAC_MSB = 95;
  localparam int unsigned MAC_LSB = 48;
  localparam int unsigned IP_MSB  = 47;
  localparam int unsigned IP_LSB  = 16;
  localparam int unsigned LEN_MSB = 15;
  localparam int unsigned LEN_LSB = 0;

  // Largest payload forwarded; anything longer is drained and dropped.
  localparam int unsigned DEFAULT_MAX_LEN = 1472;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    DRAIN,
    STATUS
  } arb_state_t;

  function automatic logic [47:0] status_mac(input logic [STATUS_W-1:0] s);
    return s[MAC_MSB:MAC_LSB];
  endfunction

  function automatic logic [31:0] status_ip(input logic [STATUS_W-1:0] s);
    return s[IP_MSB:IP_LSB];
  endfunction

  function automatic logic [15:0] status_len(input logic [STATUS_W-1:0] s);
    return s[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker. Returns the first requesting channel at
//   or after rr_ptr, searching in wrap-around order.
// Ports:
//   req     in   N_PORTS     request vector
//   rr_ptr  in   log2(N)     channel with highest priority this pick
//   gnt     out  N_PORTS     one-hot winner (0 when no request)
//   idx     out  log2(N)     binary index of the winner
//   any     out  1           at least one request present
module rr_arbiter #(
  parameter int unsigned N_PORTS = 4
) (
  input  logic [N_PORTS-1:0]         req,
  input  logic [$clog2(N_PORTS)-1:0] rr_ptr,
  output logic [N_PORTS-1:0]         gnt,
  output logic [$clog2(N_PORTS)-1:0] idx,
  output logic                       any
);

  localparam int unsigned IW = $clog2(N_PORTS);

  always_comb begin
    logic [IW:0]   cand;
    logic [IW-1:0] cidx;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    cidx = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      // Explicit wrap so non-power-of-two channel counts work.
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_PORTS)) begin
        cand = cand - (IW+1)'(N_PORTS);
      end
      cidx = cand[IW-1:0];
      if (!any && req[cidx]) begin
        any       = 1'b1;
        idx       = cidx;
        gnt[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_port_arbiter.sv
// udp_tx_port_arbiter
//   Merges N_PORTS show-ahead per-port TX FIFO pairs (byte data + 96-bit
//   status) into the single UDP core TX FIFO pair. Whole packets are moved,
//   channels are served round-robin, payloads longer than MAX_LEN are drained
//   from their channel and dropped. Data path is combinational (no register
//   between the channel mux and tx_fifo_data).
// Optional feature: define UDP_ARB_STATS_EN to add pkt_count, one wrapping
//   32-bit counter per channel of status words written (drops not counted).
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ch_status / ch_status_empty  per-channel head status word / empty flag
//   ch_status_read               one-hot status pop
//   ch_data / ch_data_empty      per-channel head data byte / empty flag
//   ch_data_read                 one-hot data pop
//   tx_fifo_data(_write/_full)   byte write port of the UDP core FIFO
//   tx_fifo_status(_write/_full) status write port of the UDP core FIFO
//   pkt_count                    per-channel packet counters (UDP_ARB_STATS_EN)
//   grant                        one-hot owner of the output, 0 when idle
//   drop_pulse                   one cycle when an oversized packet is drained
module udp_tx_port_arbiter
  import udp_arb_pkg::*;
#(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_PORTS*STATUS_W-1:0]    ch_status,
  input  logic [N_PORTS-1:0]             ch_status_empty,
  output logic [N_PORTS-1:0]             ch_status_read,
  input  logic [N_PORTS*8-1:0]           ch_data,
  input  logic [N_PORTS-1:0]             ch_data_empty,
  output logic [N_PORTS-1:0]             ch_data_read,
  output logic [7:0]                     tx_fifo_data,
  output logic                           tx_fifo_data_write,
  input  logic                           tx_fifo_data_full,
  output logic [STATUS_W-1:0]            tx_fifo_status,
  output logic                           tx_fifo_status_write,
  input  logic                           tx_fifo_status_full,
`ifdef UDP_ARB_STATS_EN
  output logic [N_PORTS*32-1:0]          pkt_count,
`endif
  output logic [N_PORTS-1:0]             grant,
  output logic                           drop_pulse
);

  localparam int unsigned IW = $clog2(N_PORTS);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  arb_state_t state_q, state_d;

  logic [IW-1:0]       sel_q;
  logic [IW-1:0]       rr_ptr;
  logic [15:0]         len_q;
  logic [15:0]         cnt_q;
  logic [STATUS_W-1:0] status_q;

  logic [STATUS_W-1:0] st_arr [N_PORTS];
  logic [7:0]          dt_arr [N_PORTS];

  logic [N_PORTS-1:0]  pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [STATUS_W-1:0] in_status;
  logic [15:0]         in_len;

  logic accept;
  logic advance;
  logic last;
  logic release_ch;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
    assign st_arr[k] = ch_status[k*STATUS_W +: STATUS_W];
    assign dt_arr[k] = ch_data[k*8 +: 8];
  end

  rr_arbiter #(
    .N_PORTS(N_PORTS)
  ) u_rr (
    .req    (~ch_status_empty),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign in_status      = st_arr[pick_idx];
  assign in_len         = status_len(in_status);
  assign last           = (cnt_q == len_q - 16'd1);
  assign tx_fifo_status = status_q;
  // Gated so the data bus reads 0 outside COPY, including during reset.
  assign tx_fifo_data   = (state_q == COPY) ? dt_arr[sel_q] : '0;
  assign release_ch     = tx_fifo_status_write | drop_pulse;

  always_comb begin
    state_d              = state_q;
    ch_status_read       = '0;
    ch_data_read         = '0;
    tx_fifo_data_write   = 1'b0;
    tx_fifo_status_write = 1'b0;
    drop_pulse           = 1'b0;
    accept               = 1'b0;
    advance              = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gate keeps the status pop quiet while reset is held.
        if (reset_n && pick_any && !tx_fifo_status_full) begin
          accept         = 1'b1;
          ch_status_read = pick_gnt;
          if (in_len == 16'd0) begin
            state_d = STATUS;
          end else if (in_len > MAX_LEN16) begin
            state_d = DRAIN;
          end else begin
            state_d = COPY;
          end
        end
      end
      COPY: begin
        if (!ch_data_empty[sel_q] && !tx_fifo_data_full) begin
          advance             = 1'b1;
          ch_data_read[sel_q] = 1'b1;
          tx_fifo_data_write  = 1'b1;
          if (last) begin
            state_d = STATUS;
          end
        end
      end
      DRAIN: begin
        if (!ch_data_empty[sel_q]) begin
          advance             = 1'b1;
          ch_data_read[sel_q] = 1'b1;
          if (last) begin
            drop_pulse = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      STATUS: begin
        if (!tx_fifo_status_full) begin
          tx_fifo_status_write = 1'b1;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      grant    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q    <= pick_idx;
        status_q <= in_status;
        len_q    <= in_len;
        cnt_q    <= '0;
        grant    <= pick_gnt;
      end else if (advance) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (release_ch) begin
        grant  <= '0;
        rr_ptr <= (sel_q == IW'(N_PORTS - 1)) ? '0 : sel_q + IW'(1);
      end
    end
  end

`ifdef UDP_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (tx_fifo_status_write) begin
      pkt_count[{sel_q, 5'b0} +: 32] <= pkt_count[{sel_q, 5'b0} +: 32] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_port_arbiter.sv
// tb_udp_tx_port_arbiter
//   Directed bench for udp_tx_port_arbiter. Per-channel input FIFOs are
//   modelled with queues; expected output events (data bytes, status words,
//   drops) are queued in the order the round-robin rules predict and popped
//   as the DUT produces them.
module tb_udp_tx_port_arbiter;
  import udp_arb_pkg::*;

  localparam int unsigned N    = 4;
  localparam int          MAXL = 1472;

  localparam logic [1:0] EV_DATA = 2'd0;
  localparam logic [1:0] EV_STAT = 2'd1;
  localparam logic [1:0] EV_DROP = 2'd2;
  localparam logic [1:0] EV_NONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [95:0] val;
  } ev_t;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic              reset_n;
  logic [N*96-1:0]   ch_status;
  logic [N-1:0]      ch_status_empty;
  logic [N-1:0]      ch_status_read;
  logic [N*8-1:0]    ch_data;
  logic [N-1:0]      ch_data_empty;
  logic [N-1:0]      ch_data_read;
  logic [7:0]        tx_fifo_data;
  logic              tx_fifo_data_write;
  logic              tx_fifo_data_full;
  logic [95:0]       tx_fifo_status;
  logic              tx_fifo_status_write;
  logic              tx_fifo_status_full;
  logic [N-1:0]      grant;
  logic              drop_pulse;
`ifdef UDP_ARB_STATS_EN
  logic [N*32-1:0]   pkt_count;
`endif

  udp_tx_port_arbiter #(
    .N_PORTS(N),
    .MAX_LEN(MAXL)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .ch_status            (ch_status),
    .ch_status_empty      (ch_status_empty),
    .ch_status_read       (ch_status_read),
    .ch_data              (ch_data),
    .ch_data_empty        (ch_data_empty),
    .ch_data_read         (ch_data_read),
    .tx_fifo_data         (tx_fifo_data),
    .tx_fifo_data_write   (tx_fifo_data_write),
    .tx_fifo_data_full    (tx_fifo_data_full),
    .tx_fifo_status       (tx_fifo_status),
    .tx_fifo_status_write (tx_fifo_status_write),
    .tx_fifo_status_full  (tx_fifo_status_full),
`ifdef UDP_ARB_STATS_EN
    .pkt_count            (pkt_count),
`endif
    .grant                (grant),
    .drop_pulse           (drop_pulse)
  );

  logic [95:0] in_st [N][$];
  logic [7:0]  in_d  [N][$];
  logic [95:0] pk_st [N][$];
  logic [7:0]  pk_d  [N][$];
  ev_t         ev_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pop_cyc, first_wr, last_wr, sw_cyc, wr_since_pop, drops, nwr;
  int pop_cnt [N];
  logic [N-1:0] last_pop_strobe;
  logic [N-1:0] grant_at_first;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < int'(N); k++) begin
      ch_status_empty[k]    = (in_st[k].size() == 0);
      ch_status[k*96 +: 96] = (in_st[k].size() != 0) ? in_st[k][0] : '0;
      ch_data_empty[k]      = (in_d[k].size() == 0);
      ch_data[k*8 +: 8]     = (in_d[k].size() != 0) ? in_d[k][0] : '0;
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    logic [95:0] s;
    logic [7:0]  b;
    s = {48'h02_00_00_00_00_00 + 48'(ch), 32'($urandom), 16'(len)};
    in_st[ch].push_back(s);
    pk_st[ch].push_back(s);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      in_d[ch].push_back(b);
      pk_d[ch].push_back(b);
    end
    drive();
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [95:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    ev_q.push_back(e);
  endtask

  // Queue the expected output events for the next packet of channel ch.
  task automatic expect_next(input int ch);
    logic [95:0] s;
    logic [7:0]  b;
    int l;
    s = pk_st[ch].pop_front();
    l = 32'(s[15:0]);
    if (l > MAXL) begin
      for (int i = 0; i < l; i++) b = pk_d[ch].pop_front();
      push_ev(EV_DROP, '0);
    end else begin
      for (int i = 0; i < l; i++) push_ev(EV_DATA, 96'(pk_d[ch].pop_front()));
      push_ev(EV_STAT, s);
    end
  endtask

  function automatic ev_t next_ev();
    ev_t e;
    e.kind = EV_NONE;
    e.val  = '0;
    if (ev_q.size() != 0) e = ev_q.pop_front();
    return e;
  endfunction

  function automatic bit inputs_pending();
    for (int k = 0; k < int'(N); k++)
      if (in_st[k].size() != 0 || in_d[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: observe at the falling edge, apply FIFO pops just after the rising edge.
  task automatic cycle();
    logic [N-1:0] sr, dr;
    ev_t e;
    @(negedge clk);
    sr = ch_status_read;
    dr = ch_data_read;
    if (sr != '0) begin
      chk("status_read_onehot", 96'($onehot(sr)), 96'd1);
      pop_cyc = cyc;
      wr_since_pop = 0;
      last_pop_strobe = sr;
    end
    if (dr != '0) chk("data_read_onehot", 96'($onehot(dr)), 96'd1);
    if (tx_fifo_data_write) begin
      chk("data_write_while_full", 96'(tx_fifo_data_full), 96'd0);
      if (wr_since_pop == 0) begin
        first_wr = cyc;
        grant_at_first = grant;
      end
      wr_since_pop++;
      last_wr = cyc;
      nwr++;
      e = next_ev();
      chk("data_event_kind", 96'(e.kind), 96'(EV_DATA));
      chk("data_byte", 96'(tx_fifo_data), 96'(e.val[7:0]));
    end
    if (tx_fifo_status_write) begin
      chk("status_write_while_full", 96'(tx_fifo_status_full), 96'd0);
      sw_cyc = cyc;
      e = next_ev();
      chk("status_event_kind", 96'(e.kind), 96'(EV_STAT));
      chk("status_word", tx_fifo_status, e.val);
    end
    if (drop_pulse) begin
      drops++;
      e = next_ev();
      chk("drop_event_kind", 96'(e.kind), 96'(EV_DROP));
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < int'(N); k++) begin
      if (sr[k]) begin
        chk("status_pop_nonempty", 96'(in_st[k].size() != 0), 96'd1);
        if (in_st[k].size() != 0) void'(in_st[k].pop_front());
      end
      if (dr[k]) begin
        chk("data_pop_nonempty", 96'(in_d[k].size() != 0), 96'd1);
        if (in_d[k].size() != 0) void'(in_d[k].pop_front());
        pop_cnt[k]++;
      end
    end
    drive();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((ev_q.size() != 0 || inputs_pending()) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_events_left"}, 96'(ev_q.size()), 96'd0);
    chk({tag, "_inputs_left"}, 96'(inputs_pending()), 96'd0);
    repeat (3) cycle();
    chk({tag, "_grant_idle"}, 96'(grant), 96'd0);
  endtask

  task automatic clear_counters();
    nwr = 0;
    drops = 0;
    wr_since_pop = 0;
    for (int k = 0; k < int'(N); k++) pop_cnt[k] = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_status_read"}, 96'(ch_status_read), 96'd0);
    chk({tag, "_data_read"}, 96'(ch_data_read), 96'd0);
    chk({tag, "_data"}, 96'(tx_fifo_data), 96'd0);
    chk({tag, "_data_write"}, 96'(tx_fifo_data_write), 96'd0);
    chk({tag, "_status"}, tx_fifo_status, 96'd0);
    chk({tag, "_status_write"}, 96'(tx_fifo_status_write), 96'd0);
    chk({tag, "_grant"}, 96'(grant), 96'd0);
    chk({tag, "_drop"}, 96'(drop_pulse), 96'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    tx_fifo_data_full = 1'b0;
    tx_fifo_status_full = 1'b0;
    pop_cyc = 0; first_wr = 0; last_wr = 0; sw_cyc = 0;
    last_pop_strobe = '0;
    grant_at_first = '0;
    clear_counters();
    drive();

    // Reset state, with a packet already waiting so the pop gate is exercised.
    add_pkt(3, 5);
    repeat (2) cycle();
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Single channel, len=5, wrap of rr_ptr from 3 back to 0.
    clear_counters();
    expect_next(3);
    run_until_done(50, "t1");
    chk("t1_pop_channel", 96'(last_pop_strobe), 96'(4'b1000));
    chk("t1_pop_to_first_write", 96'(first_wr - pop_cyc), 96'd1);
    chk("t1_consecutive_writes", 96'(last_wr - first_wr), 96'd4);
    chk("t1_pop_to_status", 96'(sw_cyc - pop_cyc), 96'd6);
    chk("t1_grant_during_copy", 96'(grant_at_first), 96'(4'b1000));
    chk("t1_bytes", 96'(nwr), 96'd5);

    // ch0 and ch2 pending with rr_ptr=0; second ch0 packet waits behind ch2.
    clear_counters();
    add_pkt(0, 4);
    add_pkt(2, 6);
    add_pkt(0, 3);
    expect_next(0);
    expect_next(2);
    expect_next(0);
    run_until_done(100, "t2");
    chk("t2_bytes", 96'(nwr), 96'd13);
    chk("t2_last_channel", 96'(last_pop_strobe), 96'(4'b0001));

    // Backpressure: data FIFO full for 3 cycles after the third byte.
    clear_counters();
    add_pkt(2, 8);
    expect_next(2);
    n = 0;
    while (nwr < 3 && n < 20) begin
      cycle();
      n++;
    end
    chk("t3_reached_third_byte", 96'(nwr), 96'd3);
    tx_fifo_data_full = 1'b1;
    repeat (3) cycle();
    tx_fifo_data_full = 1'b0;
    run_until_done(50, "t3");
    chk("t3_bytes", 96'(nwr), 96'd8);
    chk("t3_status_after_last", 96'(sw_cyc > last_wr), 96'd1);
    chk("t3_pop_to_status", 96'(sw_cyc - pop_cyc), 96'd12);

    // Oversized packet on ch1 is drained; ch2 is served next.
    clear_counters();
    add_pkt(1, MAXL + 1);
    add_pkt(2, 3);
    expect_next(1);
    expect_next(2);
    run_until_done(2000, "t4");
    chk("t4_drain_pops", 96'(pop_cnt[1]), 96'(MAXL + 1));
    chk("t4_drop_pulses", 96'(drops), 96'd1);
    chk("t4_bytes_written", 96'(nwr), 96'd3);
    chk("t4_next_channel", 96'(last_pop_strobe), 96'(4'b0100));

    // Zero-length packet: status only, one cycle after the pop.
    clear_counters();
    add_pkt(1, 0);
    expect_next(1);
    run_until_done(20, "t5");
    chk("t5_pop_to_status", 96'(sw_cyc - pop_cyc), 96'd1);
    chk("t5_no_data", 96'(nwr), 96'd0);
    chk("t5_no_data_pops", 96'(pop_cnt[1]), 96'd0);

    // Reset in the middle of a ch2 packet, then rr_ptr must be back at 0.
    clear_counters();
    add_pkt(2, 20);
    expect_next(2);
    n = 0;
    while (nwr < 5 && n < 30) begin
      cycle();
      n++;
    end
    chk("t6_in_copy", 96'(nwr), 96'd5);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    for (int k = 0; k < int'(N); k++) begin
      in_st[k].delete();
      in_d[k].delete();
      pk_st[k].delete();
      pk_d[k].delete();
    end
    ev_q.delete();
    drive();
    repeat (2) cycle();
    reset_n = 1'b1;
    clear_counters();
    add_pkt(3, 4);
    add_pkt(0, 2);
    expect_next(0);
    expect_next(3);
    run_until_done(50, "t6");
    chk("t6_bytes", 96'(nwr), 96'd6);
    chk("t6_last_channel", 96'(last_pop_strobe), 96'(4'b1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
